// File: rtl/a51_keystream_gen.sv
// A5/1 keystream generator: key/frame load, majority-clocked mix, then OUT_W-bit words over valid/ready.
// Optional macro A51_STATE_OBS_EN adds dbg_state/dbg_phase observation ports.
module a51_keystream_gen #(
    parameter int KEY_W      = 64,
    parameter int FRAME_W    = 22,
    parameter int MIX_CYCLES = 100,
    parameter int KS_BITS    = 228,
    parameter int OUT_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [KEY_W-1:0]   key,
    input  logic [FRAME_W-1:0] frame,
    output logic               busy,
    output logic [OUT_W-1:0]   ks_data,
    output logic               ks_valid,
    input  logic               ks_ready,
    output logic               done
`ifdef A51_STATE_OBS_EN
    ,
    output logic [63:0]        dbg_state,
    output logic [2:0]         dbg_phase
`endif
);

    localparam int NWORDS  = KS_BITS / OUT_W;
    localparam int M1      = (KEY_W > FRAME_W) ? KEY_W : FRAME_W;
    localparam int M2      = (M1 > MIX_CYCLES) ? M1 : MIX_CYCLES;
    localparam int CNT_MAX = (M2 > NWORDS) ? M2 : NWORDS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(NWORDS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(OUT_W - 1);

    generate
        if (KS_BITS % OUT_W != 0) begin : g_bad_ks_bits
            $error("KS_BITS must be a multiple of OUT_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_KEY   = 3'd1,
        S_LOAD_FRAME = 3'd2,
        S_MIX        = 3'd3,
        S_GEN        = 3'd4,
        S_HOLD       = 3'd5
    } state_t;

    state_t             r_state;
    logic [18:0]        r_r1;
    logic [21:0]        r_r2;
    logic [22:0]        r_r3;
    logic [KEY_W-1:0]   r_key;
    logic [FRAME_W-1:0] r_frame;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIT_W-1:0]   r_bit;
    logic [OUT_W-1:0]   r_col;
    logic [OUT_W-1:0]   r_ks_data;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    logic        w_load, w_step, w_in, w_maj;
    logic        w_en1, w_en2, w_en3, w_bit;
    logic [18:0] w_r1_n;
    logic [21:0] w_r2_n;
    logic [22:0] w_r3_n;
    logic [OUT_W-1:0] w_col_n;

    assign w_load = (r_state == S_LOAD_KEY) || (r_state == S_LOAD_FRAME);
    assign w_step = w_load || (r_state == S_MIX) || (r_state == S_GEN);
    // Key and frame latches are consumed LSB first by shifting right each load cycle.
    assign w_in   = (r_state == S_LOAD_KEY)   ? r_key[0]   :
                    (r_state == S_LOAD_FRAME) ? r_frame[0] : 1'b0;
    assign w_maj  = (r_r1[8] & r_r2[10]) | (r_r1[8] & r_r3[10]) | (r_r2[10] & r_r3[10]);

    assign w_en1 = w_load || (r_r1[8]  == w_maj);
    assign w_en2 = w_load || (r_r2[10] == w_maj);
    assign w_en3 = w_load || (r_r3[10] == w_maj);

    assign w_r1_n = w_en1 ? {r_r1[17:0], r_r1[13] ^ r_r1[16] ^ r_r1[17] ^ r_r1[18] ^ w_in} : r_r1;
    assign w_r2_n = w_en2 ? {r_r2[20:0], r_r2[20] ^ r_r2[21] ^ w_in} : r_r2;
    assign w_r3_n = w_en3 ? {r_r3[21:0], r_r3[7] ^ r_r3[20] ^ r_r3[21] ^ r_r3[22] ^ w_in} : r_r3;

    assign w_bit   = w_r1_n[18] ^ w_r2_n[21] ^ w_r3_n[22];
    assign w_col_n = (r_col << 1) | OUT_W'(w_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_r1      <= '0;
            r_r2      <= '0;
            r_r3      <= '0;
            r_key     <= '0;
            r_frame   <= '0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_col     <= '0;
            r_ks_data <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_step) begin
                r_r1 <= w_r1_n;
                r_r2 <= w_r2_n;
                r_r3 <= w_r3_n;
            end
            case (r_state)
                // The done cycle is already IDLE; start is held off until it clears.
                S_IDLE: if (start && !r_done) begin
                    r_key   <= key;
                    r_frame <= frame;
                    r_r1    <= '0;
                    r_r2    <= '0;
                    r_r3    <= '0;
                    r_cnt   <= '0;
                    r_bit   <= '0;
                    r_col   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= S_LOAD_KEY;
                end
                S_LOAD_KEY: begin
                    r_key <= r_key >> 1;
                    if (r_cnt == KEY_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD_FRAME;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LOAD_FRAME: begin
                    r_frame <= r_frame >> 1;
                    if (r_cnt == FRAME_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_MIX;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_MIX: begin
                    if (r_cnt == MIX_LAST) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= S_GEN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GEN: begin
                    r_col <= w_col_n;
                    if (r_bit == BIT_LAST) begin
                        r_ks_data <= w_col_n;
                        r_valid   <= 1'b1;
                        r_bit     <= '0;
                        r_state   <= S_HOLD;
                    end else begin
                        r_bit <= r_bit + BIT_W'(1);
                    end
                end
                // r_cnt counts accepted words from here on.
                S_HOLD: if (ks_ready) begin
                    r_valid <= 1'b0;
                    if (r_cnt == WORD_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= S_GEN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign ks_data  = r_ks_data;
    assign ks_valid = r_valid;
    assign done     = r_done;

`ifdef A51_STATE_OBS_EN
    assign dbg_state = {r_r3, r_r2, r_r1};
    assign dbg_phase = r_state;
`endif

endmodule

// File: tb/tb_a51_keystream_gen.sv
// Directed bench for a51_keystream_gen: scenario table of sessions plus reset corner sequences.
module tb_a51_keystream_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ks_ready = 1'b1;
    logic [63:0] key = '0;
    logic [21:0] frame = '0;
    logic        busy, ks_valid, done;
    logic [3:0]  ks_data;
`ifdef A51_STATE_OBS_EN
    logic [63:0] dbg_state;
    logic [2:0]  dbg_phase;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    a51_keystream_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
        .frame    (frame),
        .busy     (busy),
        .ks_data  (ks_data),
        .ks_valid (ks_valid),
        .ks_ready (ks_ready),
        .done     (done)
`ifdef A51_STATE_OBS_EN
        ,
        .dbg_state(dbg_state),
        .dbg_phase(dbg_phase)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] key;
        logic [21:0] frame;
        int          stall_at;
        int          stall_len;
        int          busy_start_at;
        bit          chk_head;
        logic [115:0] head;
    } scen_t;

    scen_t tbl [4];

    localparam logic [63:0]  GOLD_KEY   = 64'hEFCDAB8967452312;
    localparam logic [21:0]  GOLD_FRAME = 22'h134;
    localparam logic [115:0] GOLD_HEAD  = 116'h534EAA582FE8151AB6E1855A728C0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Bit-serial A5/1 reference; first keystream bit ends at ks[227].
    task automatic ref_gen(input logic [63:0] k, input logic [21:0] f, output logic [227:0] ks);
        logic [18:0] a;
        logic [21:0] b;
        logic [22:0] c;
        logic [63:0] kk;
        logic [21:0] ff;
        logic        ib, m;
        int          votes;
        a = '0; b = '0; c = '0; kk = k; ff = f; ks = '0;
        for (int i = 0; i < 86; i++) begin
            if (i < 64) begin ib = kk[0]; kk = kk >> 1; end
            else        begin ib = ff[0]; ff = ff >> 1; end
            a = {a[17:0], a[13] ^ a[16] ^ a[17] ^ a[18] ^ ib};
            b = {b[20:0], b[20] ^ b[21] ^ ib};
            c = {c[21:0], c[7] ^ c[20] ^ c[21] ^ c[22] ^ ib};
        end
        for (int i = 0; i < 100 + 228; i++) begin
            votes = int'(a[8]) + int'(b[10]) + int'(c[10]);
            m = (votes >= 2);
            if (a[8]  == m) a = {a[17:0], a[13] ^ a[16] ^ a[17] ^ a[18]};
            if (b[10] == m) b = {b[20:0], b[20] ^ b[21]};
            if (c[10] == m) c = {c[21:0], c[7] ^ c[20] ^ c[21] ^ c[22]};
            if (i >= 100) ks = {ks[226:0], a[18] ^ b[21] ^ c[22]};
        end
    endtask

    task automatic run_session(input scen_t s);
        logic [227:0] rks;
        logic [115:0] hd;
        logic [3:0]   held;
        logic         prev_v;
        int           cyc, words, prev_cyc, stall_left;
        ref_gen(s.key, s.frame, rks);
        hd = s.head;
        key = s.key; frame = s.frame; ks_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({s.name, " busy_after_start"}, 64'(busy), 64'd1);
        cyc = 0; words = 0; prev_cyc = 0; stall_left = 0; prev_v = 1'b0; held = '0;
        while (words < 57 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == s.busy_start_at) begin
                start = 1'b1; key = ~s.key; frame = ~s.frame;
            end else if (start) begin
                start = 1'b0; key = s.key; frame = s.frame;
            end
            if (stall_left > 0) begin
                chk({s.name, " stall_hold"}, {59'd0, ks_valid, ks_data}, {59'd0, 1'b1, held});
                stall_left--;
                if (stall_left == 0) ks_ready = 1'b1;
            end else if (ks_valid && !prev_v) begin
                if (words == 0)
                    chk({s.name, " first_valid_latency"}, 64'(cyc), 64'd190);
                else if (s.stall_len == 0)
                    chk({s.name, " word_spacing"}, 64'(cyc - prev_cyc), 64'd5);
                chk({s.name, " word_vs_model"}, 64'(ks_data), 64'(rks[227:224]));
                if (s.chk_head && words < 29)
                    chk({s.name, " word_vs_table"}, 64'(ks_data), 64'(hd[115:112]));
                if (words == s.stall_at && s.stall_len > 0) begin
                    ks_ready = 1'b0; stall_left = s.stall_len; held = ks_data;
                end
                rks = rks << 4;
                hd = hd << 4;
                prev_cyc = cyc;
                words++;
            end
            prev_v = ks_valid;
        end
        chk({s.name, " word_count"}, 64'(words), 64'd57);
        @(posedge clk); #1;
        chk({s.name, " done_pulse"}, {62'd0, done, busy}, {62'd0, 1'b1, 1'b0});
        // start during the done cycle must not launch a new session
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({s.name, " done_clear_start_ignored"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        tbl[0] = '{"golden",    GOLD_KEY, GOLD_FRAME, -1, 0,  -1, 1'b1, GOLD_HEAD};
        tbl[1] = '{"backpress", GOLD_KEY, GOLD_FRAME, 3,  50, -1, 1'b1, GOLD_HEAD};
        tbl[2] = '{"busystart", GOLD_KEY, GOLD_FRAME, -1, 0,  40, 1'b1, GOLD_HEAD};
        tbl[3] = '{"zero",      64'd0,    22'd0,      -1, 0,  -1, 1'b1, 116'd0};

        #1;
        chk("reset_outputs", {60'd0, busy, ks_valid, done, |ks_data}, 64'd0);
`ifdef A51_STATE_OBS_EN
        chk("reset_dbg_state", dbg_state, 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 4; t++) run_session(tbl[t]);

        // mid-session reset during MIX, then a clean restart
        key = GOLD_KEY; frame = GOLD_FRAME; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (120) @(posedge clk);
        #1;
        chk("mid_busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {60'd0, busy, ks_valid, done, |ks_data}, 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_idle", 64'(busy), 64'd0);
        run_session(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
